// File: rtl/mseq_checker_if.sv
// Serial bit-stream bus between a sequence source and the mseq_checker receiver.
// The master drives the received bits and configuration; the slave (checker) returns status.
interface mseq_checker_if #(
    parameter int N     = 4,
    parameter int CNT_W = 16
);
    // bit_valid is a strobe without backpressure: each high cycle carries one new bit_in,
    // and the checker always consumes it in that same cycle (there is no ready).
    logic             bit_in;
    logic             bit_valid;
    logic [N-1:0]     taps;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             period_mark;
    logic [1:0]       state_dbg;

    modport master (
        output bit_in, bit_valid, taps, clr_cnt,
        input  locked, err_pulse, err_cnt, period_mark, state_dbg
    );

    modport slave (
        input  bit_in, bit_valid, taps, clr_cnt,
        output locked, err_pulse, err_cnt, period_mark, state_dbg
    );
endinterface

// File: rtl/mseq_checker.sv
// Self-synchronising M-sequence checker: acquires lock on a received LFSR stream,
// then flywheels on its own predictions to flag and count bit errors.
module mseq_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_THR = 3,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mseq_checker_if.slave bus
);
    localparam int FILL_W = $clog2(N + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       sh_q, sh_d;
    logic [N-1:0]       taps_q, taps_d;
    logic               tseen_q, tseen_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               mark_q, mark_d;

    logic pred, bit_ok, taps_chg, cnt_inc;

    assign pred     = ^(sh_q & bus.taps);
    assign bit_ok   = (bus.bit_in == pred);
    // The very first bit after reset only latches taps; it is not treated as a change.
    assign taps_chg = tseen_q && (bus.taps != taps_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SEARCH;
            sh_q     <= '0;
            taps_q   <= '0;
            tseen_q  <= 1'b0;
            fill_q   <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            mark_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            taps_q   <= taps_d;
            tseen_q  <= tseen_d;
            fill_q   <= fill_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            mark_q   <= mark_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        taps_d  = taps_q;
        tseen_d = tseen_q;
        fill_d  = fill_q;
        good_d  = good_q;
        miss_d  = miss_q;
        if (bus.bit_valid) begin
            taps_d  = bus.taps;
            tseen_d = 1'b1;
            if (taps_chg) begin
                state_d = S_SEARCH;
                fill_d  = '0;
                good_d  = '0;
                miss_d  = '0;
            end else begin
                case (state_q)
                    S_SEARCH: begin
                        sh_d   = {sh_q[N-2:0], bus.bit_in};
                        fill_d = fill_q + FILL_W'(1);
                        if (fill_d == FILL_W'(N)) begin
                            // An all-zero register is a lock-up state for any taps: refill instead.
                            fill_d = '0;
                            if (sh_d != '0) begin
                                state_d = S_CHECK;
                                good_d  = '0;
                            end
                        end
                    end
                    S_CHECK: begin
                        sh_d = {sh_q[N-2:0], bus.bit_in};
                        if (bit_ok) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_d == GOOD_W'(LOCK_CNT)) begin
                                state_d = S_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = S_SEARCH;
                            fill_d  = '0;
                            good_d  = '0;
                        end
                    end
                    S_LOCKED: begin
                        // Flywheel on the prediction so a corrupted bit never enters the register.
                        sh_d = {sh_q[N-2:0], pred};
                        if (bit_ok) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                            if (miss_d == MISS_W'(LOSS_THR)) begin
                                state_d = S_SEARCH;
                                fill_d  = '0;
                                good_d  = '0;
                                miss_d  = '0;
                            end
                        end
                    end
                    default: begin
                        state_d = S_SEARCH;
                        fill_d  = '0;
                        good_d  = '0;
                        miss_d  = '0;
                    end
                endcase
            end
        end
    end

    // Output logic
    always_comb begin
        cnt_inc  = bus.bit_valid && !taps_chg && (state_q == S_LOCKED) && !bit_ok;
        err_d    = cnt_inc;
        mark_d   = bus.bit_valid && !taps_chg && (state_q == S_LOCKED) && (sh_d == '1);
        locked_d = (state_d == S_LOCKED);
        // Clear first, then count, so a clear coinciding with an error leaves one.
        cnt_d    = bus.clr_cnt ? '0 : cnt_q;
        if (cnt_inc && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    assign bus.locked      = locked_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_cnt     = cnt_q;
    assign bus.period_mark = mark_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_mseq_checker.sv
// Bench for mseq_checker: directed phases plus randomized gaps/errors, checked every cycle
// against a queue-based behavioural model of the receiver.
module tb_mseq_checker;
    localparam int N        = 4;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_THR = 3;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 6;
    localparam int MAX_MAIN = 65535;
    localparam int MAX_SAT  = 63;

    logic clk;
    logic rst_n;

    mseq_checker_if #(.N(N), .CNT_W(CNT_W)) m_if ();
    mseq_checker_if #(.N(N), .CNT_W(SAT_W)) s_if ();

    // Narrow-counter twin shares the stimulus so saturation is reachable in a short run.
    assign s_if.bit_in    = m_if.bit_in;
    assign s_if.bit_valid = m_if.bit_valid;
    assign s_if.taps      = m_if.taps;
    assign s_if.clr_cnt   = m_if.clr_cnt;

    mseq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    mseq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .CNT_W(SAT_W)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    typedef enum {M_SEARCH, M_CHECK, M_LOCKED} mode_t;
    mode_t    m_mode;
    bit       win[$];
    int       m_fill, m_good, m_miss, m_errs;
    bit [3:0] m_taps;
    bit       m_tseen;
    bit       exp_locked, exp_err, exp_mark;

    bit ref_seq[15] = '{1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1};
    int       pos = 0;
    bit [3:0] cur_taps = 4'b1001;
    int       vbits, marks, pulses;
    int       mark_q[$];
    bit       saw_lock;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(int e, int mx);
        return (e > mx) ? mx : e;
    endfunction

    function automatic bit next_ref();
        bit b;
        b   = ref_seq[pos];
        pos = (pos + 1) % 15;
        return b;
    endfunction

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_mode = M_SEARCH;
        win    = {};
        for (int i = 0; i < N; i++) win.push_back(1'b0);
        m_fill = 0; m_good = 0; m_miss = 0; m_errs = 0;
        m_taps = '0; m_tseen = 1'b0;
        exp_locked = 1'b0; exp_err = 1'b0; exp_mark = 1'b0;
    endfunction

    // win holds the last N register bits, newest at the back; taps bit k looks k bits back.
    function automatic bit predict(bit [3:0] t);
        bit p = 1'b0;
        for (int k = 0; k < N; k++) if (t[k]) p ^= win[N-1-k];
        return p;
    endfunction

    function automatic bit win_is(bit v);
        for (int k = 0; k < N; k++) if (win[k] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push(bit b);
        win.push_back(b);
        void'(win.pop_front());
    endfunction

    function automatic void model_step(bit v, bit b, bit [3:0] t, bit c);
        bit p;
        exp_err  = 1'b0;
        exp_mark = 1'b0;
        if (c) m_errs = 0;
        if (v) begin
            p = predict(t);
            if (m_tseen && (t != m_taps)) begin
                m_mode = M_SEARCH; m_fill = 0; m_good = 0; m_miss = 0;
            end else if (m_mode == M_SEARCH) begin
                push(b);
                m_fill++;
                if (m_fill == N) begin
                    m_fill = 0;
                    if (!win_is(1'b0)) begin m_mode = M_CHECK; m_good = 0; end
                end
            end else if (m_mode == M_CHECK) begin
                push(b);
                if (b == p) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = M_LOCKED; m_miss = 0; end
                end else begin
                    m_mode = M_SEARCH; m_fill = 0; m_good = 0;
                end
            end else begin
                push(p);
                if (b != p) begin
                    exp_err = 1'b1;
                    m_errs++;
                    m_miss++;
                    if (m_miss == LOSS_THR) begin m_mode = M_SEARCH; m_fill = 0; m_good = 0; end
                end else begin
                    m_miss = 0;
                end
                exp_mark = win_is(1'b1);
            end
            m_taps  = t;
            m_tseen = 1'b1;
        end
        exp_locked = (m_mode == M_LOCKED);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(bit v, bit b, bit c);
        @(negedge clk);
        m_if.bit_valid = v;
        m_if.bit_in    = b;
        m_if.clr_cnt   = c;
        m_if.taps      = cur_taps;
        model_step(v, b, cur_taps, c);
        if (v) vbits++;
        @(posedge clk);
        #1;
        chk("locked",      m_if.locked,      exp_locked);
        chk("err_pulse",   m_if.err_pulse,   exp_err);
        chk("period_mark", m_if.period_mark, exp_mark);
        chk("err_cnt",     m_if.err_cnt,     sat(m_errs, MAX_MAIN));
        chk("sat_err_cnt", s_if.err_cnt,     sat(m_errs, MAX_SAT));
        chk("sat_locked",  s_if.locked,      exp_locked);
        if (m_if.period_mark) begin marks++; mark_q.push_back(vbits); end
        if (m_if.err_pulse) pulses++;
        if (m_if.locked) saw_lock = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, bit'($urandom), 1'b0);
    endtask

    task automatic send(bit b, int gap);
        cyc(1'b1, b, 1'b0);
        idle(gap);
    endtask

    task automatic relock(string tag, int limit, output int used);
        used = 0;
        while (!m_if.locked && used < limit) begin
            send(next_ref(), $urandom_range(0, 1));
            used++;
        end
        chk(tag, m_if.locked, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_if.bit_valid = 1'b0;
        m_if.clr_cnt   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_locked",      m_if.locked,      1'b0);
        chk("rst_err_pulse",   m_if.err_pulse,   1'b0);
        chk("rst_err_cnt",     m_if.err_cnt,     16'd0);
        chk("rst_period_mark", m_if.period_mark, 1'b0);
        chk("rst_sat_err_cnt", s_if.err_cnt,     6'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int used;
        int sp1, sp2;
        bit flip;
        rst_n          = 1'b0;
        m_if.bit_in    = 1'b0;
        m_if.bit_valid = 1'b0;
        m_if.clr_cnt   = 1'b0;
        m_if.taps      = cur_taps;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_locked",  m_if.locked,  1'b0);
        chk("reset_err_cnt", m_if.err_cnt, 16'd0);
        rst_n = 1'b1;

        // Lock acquisition: valid every 3rd clock, lock visible right after the 12th bit.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, next_ref(), 1'b0);
            if (i == 11) chk("no_lock_after_11", m_if.locked, 1'b0);
            if (i == 12) chk("lock_after_12",    m_if.locked, 1'b1);
            idle(2);
        end
        chk("acq_err_cnt", m_if.err_cnt, 16'd0);

        // Period mark over 45 bits.
        marks = 0; pulses = 0; vbits = 0; mark_q = {};
        for (int i = 0; i < 45; i++) send(next_ref(), $urandom_range(0, 2));
        sp1 = (mark_q.size() >= 2) ? mark_q[1] - mark_q[0] : -1;
        sp2 = (mark_q.size() >= 3) ? mark_q[2] - mark_q[1] : -1;
        chk("period_marks",   marks,  3);
        chk("period_space_1", sp1,    15);
        chk("period_space_2", sp2,    15);
        chk("period_pulses",  pulses, 0);

        // Single error: flywheel absorbs it.
        pulses = 0;
        for (int i = 0; i < 5; i++) send(next_ref(), 0);
        send(~next_ref(), 1);
        for (int i = 0; i < 20; i++) send(next_ref(), $urandom_range(0, 2));
        chk("single_pulses",  pulses,       1);
        chk("single_err_cnt", m_if.err_cnt, 16'd1);
        chk("single_locked",  m_if.locked,  1'b1);

        // Clear alone.
        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_alone", m_if.err_cnt, 16'd0);

        // Loss of lock after three consecutive errors, then re-lock.
        send(~next_ref(), 1);
        send(~next_ref(), 0);
        send(~next_ref(), 0);
        chk("loss_err_cnt", m_if.err_cnt, 16'd3);
        chk("loss_locked",  m_if.locked,  1'b0);
        relock("relock", 40, used);
        chk("relock_within_12", (used <= 12), 1'b1);

        // Randomized stretch: random gaps, sparse bit errors, occasional clears.
        for (int i = 0; i < 300; i++) begin
            flip = ($urandom_range(0, 15) == 0);
            cyc(1'b1, next_ref() ^ flip, ($urandom_range(0, 49) == 0));
            idle($urandom_range(0, 2));
        end
        relock("random_relock", 40, used);

        // Counter saturation (narrow twin) and clear-with-error.
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            send(~next_ref(), 0);
            send(next_ref(), 0);
        end
        chk("main_cnt_80",   m_if.err_cnt, 16'd80);
        chk("sat_cnt_hold",  s_if.err_cnt, 6'd63);
        chk("still_locked",  m_if.locked,  1'b1);
        cyc(1'b1, ~next_ref(), 1'b1);
        chk("clr_with_err",     m_if.err_cnt, 16'd1);
        chk("sat_clr_with_err", s_if.err_cnt, 6'd1);

        // Taps change while locked, then back.
        cur_taps = 4'b1100;
        send(next_ref(), 0);
        chk("taps_chg_unlock", m_if.locked, 1'b0);
        cur_taps = 4'b1001;
        relock("taps_relock", 40, used);

        // Asynchronous reset mid-stream, then an all-zero stream.
        send(next_ref(), 0);
        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 40; i++) send(1'b0, $urandom_range(0, 2));
        chk("zero_never_locked", saw_lock,     1'b0);
        chk("zero_err_cnt",      m_if.err_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
